// File: rtl/mcycle_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer.
package mcycle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StDone
  } mc_state_e;

  localparam logic MC_MUL = 1'b0;
  localparam logic MC_DIV = 1'b1;

endpackage

// File: rtl/mcycle_sequencer.sv
// Iterative unsigned shift-add multiply / restoring divide, one bit per cycle,
// with a pipeline stall request and a one-cycle completion pulse.
module mcycle_sequencer
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mc_state_e          state_q;
  logic [CntW-1:0]    count_q;
  logic               op_q;
  logic [WIDTH-1:0]   addend_q;  // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign Busy = ((state_q == StIdle) && Start) || (state_q == StCompute);

  // Multiply step: conditional add into the high half with carry, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  end

  // Divide step: the partial remainder stays below the divisor, so it fits in WIDTH bits
  // between iterations; only the shifted trial value needs the extra bit.
  always_comb begin
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, addend_q};
    rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, addend_q}) : div_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      count_q  <= '0;
      op_q     <= MC_MUL;
      addend_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      Result1  <= '0;
      Result2  <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            op_q     <= MCycleOp;
            addend_q <= (MCycleOp == MC_DIV) ? Operand2 : Operand1;
            acc_q    <= {{WIDTH{1'b0}}, Operand2};
            rem_q    <= '0;
            quo_q    <= Operand1;
            count_q  <= '0;
            state_q  <= StCompute;
          end
        end
        StCompute: begin
          if (op_q == MC_MUL) begin
            acc_q <= mul_next;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
          end
          count_q <= count_q + 1'b1;
          if (count_q == CntLast) begin
            state_q <= StDone;
            Done    <= 1'b1;
            if (op_q == MC_MUL) begin
              Result1 <= mul_next[WIDTH-1:0];
              Result2 <= mul_next[2*WIDTH-1:WIDTH];
            end else begin
              Result1 <= quo_next;
              Result2 <= rem_next;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed bench for mcycle_sequencer: vector table plus hold-start and reset-abort sequences.
module tb_mcycle_sequencer;

  localparam int unsigned W = 32;

  logic         CLK;
  logic         RESET;
  logic         Start;
  logic         MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  int n_checks = 0;
  int n_fail   = 0;

  mcycle_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start at cycle 0, then check Busy/Done every cycle through cycle W+1 and the results after.
  task automatic run_vec(input vec_t v);
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = v.op; Operand1 = v.a; Operand2 = v.b;
    @(negedge CLK);
    chk({v.name, " busy c0"}, W'(Busy), W'(1));
    chk({v.name, " done c0"}, W'(Done), W'(0));
    for (int c = 1; c <= W + 1; c++) begin
      @(posedge CLK); #1;
      if (c == 1) begin
        Start = 1'b0; Operand1 = '1; Operand2 = '1;
      end
      @(negedge CLK);
      chk($sformatf("%s busy c%0d", v.name, c), W'(Busy), W'(c <= W));
      chk($sformatf("%s done c%0d", v.name, c), W'(Done), W'(c == W + 1));
    end
    chk({v.name, " result1"}, Result1, v.r1);
    chk({v.name, " result2"}, Result2, v.r2);
    @(negedge CLK);
    chk({v.name, " done drop"}, W'(Done), W'(0));
    chk({v.name, " result1 hold"}, Result1, v.r1);
    chk({v.name, " result2 hold"}, Result2, v.r2);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"mul ffff*10001", 1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32'h0};
    vecs[1] = '{"mul max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{"mul 7*6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0};
    vecs[3] = '{"div 100/7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2};
    vecs[4] = '{"div max/1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
    vecs[5] = '{"div by zero", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234};
    vecs[6] = '{"div max/10000", 1'b1, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF};
    vecs[7] = '{"div 5/9", 1'b1, 32'd5, 32'd9, 32'd0, 32'd5};

    RESET = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset busy", W'(Busy), W'(0));
    chk("reset done", W'(Done), W'(0));
    chk("reset result1", Result1, '0);
    chk("reset result2", Result2, '0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start held high: second op accepted at cycle W+2, operands swapped mid-run.
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'h0000_FFFF; Operand2 = 32'h0001_0001;
    for (int c = 1; c <= 2 * W + 3; c++) begin
      @(posedge CLK); #1;
      if (c == 5) begin
        MCycleOp = 1'b1; Operand1 = 32'd100; Operand2 = 32'd7;
      end
      if (c == W + 3) Start = 1'b0;
      @(negedge CLK);
      chk($sformatf("hold done c%0d", c), W'(Done), W'((c == W + 1) || (c == 2 * W + 3)));
      if (c == W + 1) begin
        chk("hold busy at done", W'(Busy), W'(0));
        chk("hold first result1", Result1, 32'hFFFF_FFFF);
        chk("hold first result2", Result2, 32'h0);
      end
      if (c == W + 2) chk("hold second accept busy", W'(Busy), W'(1));
      if (c == 2 * W + 3) begin
        chk("hold second result1", Result1, 32'd14);
        chk("hold second result2", Result2, 32'd2);
      end
    end

    // Reset at cycle 10 of a multiply aborts with no Done.
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5;
    for (int c = 1; c <= W + 6; c++) begin
      @(posedge CLK); #1;
      if (c == 1) Start = 1'b0;
      if (c == 10) RESET = 1'b1;
      if (c == 11) RESET = 1'b0;
      @(negedge CLK);
      chk($sformatf("abort done c%0d", c), W'(Done), W'(0));
      if (c == 10) chk("abort busy before edge", W'(Busy), W'(1));
      if (c == 11) begin
        chk("abort busy", W'(Busy), W'(0));
        chk("abort result1", Result1, '0);
        chk("abort result2", Result2, '0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcycle_sequencer.md
# mcycle_sequencer

Multi-cycle execution controller for the processor's multiply/divide path. It accepts a condition-qualified start from the condition-check stage, runs an iterative unsigned shift-add multiply or restoring divide over `WIDTH` cycles, and holds `Busy` high so the pipeline stalls. When the operation completes it pulses `Done` and holds the results until the next start, for the writeback path to consume.

## Interface
Parameters:
- `WIDTH`, 32: operand width in bits. Must be ≥ 4.

Ports:
- `CLK` in 1: clock. All state updates on the rising edge.
- `RESET` in 1: reset. **Synchronous, active-high.**
- `Start` in 1: start request. Already ANDed with the condition-pass result upstream.
- `MCycleOp` in 1: operation select. 0 = multiply, 1 = divide. Sampled with `Start`.
- `Operand1` in WIDTH: multiplicand or dividend. Sampled with `Start`.
- `Operand2` in WIDTH: multiplier or divisor. Sampled with `Start`.
- `Result1` out WIDTH: low product word (multiply) or quotient (divide).
- `Result2` out WIDTH: high product word (multiply) or remainder (divide).
- `Busy` out 1: stall request to the pipeline.
- `Done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- **IDLE**
  - `Start`=1: latch operands and op, clear the iteration counter, go to COMPUTE.
  - Otherwise: stay in IDLE.
- **COMPUTE**
  - Performs one iteration per cycle.
  - Counter runs 0..WIDTH-1. When the counter reaches WIDTH-1, go to DONE.
- **DONE**
  - `Done`=1 for this one cycle. The final results are presented on `Result1`/`Result2`.
  - Unconditionally return to IDLE.
  - `Start` in this cycle is ignored; the requester re-issues after `Done`.
- **Multiply** (unsigned)
  - 2·WIDTH accumulator, initialised to {0, Operand2}.
  - Each iteration: if acc[0] is set, add Operand1 into acc[2W-1:W] with carry out kept (W+1 bits); then shift the whole accumulator right by 1.
  - After WIDTH iterations: `Result2` = acc[2W-1:W], `Result1` = acc[W-1:0].
- **Divide** (unsigned restoring)
  - Partial remainder R is W+1 bits, initialised to 0. Quotient register Q is initialised to Operand1.
  - Each iteration: shift {R, Q} left by 1. Trial-subtract the divisor from R. If the result is non-negative, keep it and set Q[0]=1; otherwise restore R and set Q[0]=0.
  - `Result1` = Q, `Result2` = R[W-1:0].
- **Divide by zero**: no special path. The algorithm yields quotient = all ones and remainder = Operand1, and that is the required result.
- **Result hold**: `Result1`/`Result2` are registered. They change only at completion or reset, and hold their value through IDLE until the next completion.
- `Start` while in COMPUTE or DONE is ignored. There is no queueing.

## Timing
- **Reset values**: state = IDLE; `Result1` = 0; `Result2` = 0; `Done` = 0; `Busy` = 0; counter = 0.
- **`RESET` mid-operation**: abort on the next edge. The state returns to IDLE, the results clear to 0, and no `Done` pulse is produced.
- **`Busy` definition** (combinational): (IDLE & `Start`) | COMPUTE.
  - It is high in the same cycle `Start` is asserted, so the pipeline stalls immediately.
- **Latency**, with `Start` seen at cycle 0:
  - `Busy` is high for cycles 0..WIDTH (WIDTH+1 cycles).
  - `Done`=1 and `Busy`=0 at cycle WIDTH+1.
  - Results are valid from cycle WIDTH+1 onward.
- **Back-to-back**: the earliest next accepted `Start` is in cycle WIDTH+2 (IDLE).
- **Counter width**: $clog2(WIDTH). Wrap-around is never used; the counter is reset at each start.

## Structure
- Shared package `mcycle_pkg`:
  - State enum: IDLE / COMPUTE / DONE.
  - Op encoding: `MC_MUL` = 1'b0, `MC_DIV` = 1'b1.
- Single module; no sub-module is warranted.
- The multiply and divide iteration steps are two combinational blocks selected by the latched op. They share the counter and FSM.

## Test plan
- **Multiply**, WIDTH=32, `Start` with op=0, 0x0000_FFFF × 0x0001_0001 → at cycle 33: `Done`=1, `Result1`=0xFFFF_FFFF, `Result2`=0x0000_0000. `Busy` high on cycles 0–32.
- **Multiply, maximum operands**: 0xFFFF_FFFF × 0xFFFF_FFFF → `Result2`=0xFFFF_FFFE, `Result1`=0x0000_0001.
- **Divide**: 100 ÷ 7 → `Result1`=14, `Result2`=2. Then 0xFFFF_FFFF ÷ 1 → `Result1`=0xFFFF_FFFF, `Result2`=0.
- **Divide by zero**: 0x1234 ÷ 0 → `Result1`=0xFFFF_FFFF, `Result2`=0x1234. `Done` at cycle 33.
- **`Start` held high continuously** → the second op is accepted at cycle 34 and its `Done` arrives at cycle 67. Operands changed mid-operation do not alter the first result.
- **`RESET` asserted at cycle 10 of a multiply** → next cycle: `Busy`=0, results=0. No `Done` pulse appears for the aborted operation.
